// File: rtl/mips_pkg.sv
// Shared definitions: ALU control codes (ALU + mult/div unit) and mult/div FSM states.
package mips_pkg;

    // 4-bit ALU control codes produced by the ALU controller
    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_NOR   = 4'b1100;
    localparam logic [3:0] ALU_MULT  = 4'b1000;
    localparam logic [3:0] ALU_MULTU = 4'b1001;
    localparam logic [3:0] ALU_DIV   = 4'b1010;
    localparam logic [3:0] ALU_DIVU  = 4'b1011;
    localparam logic [3:0] ALU_MTHI  = 4'b1110;
    localparam logic [3:0] ALU_MTLO  = 4'b1111;

    // Mult/div FSM state encoding
    typedef logic [1:0] muldiv_state_t;
    localparam muldiv_state_t MD_IDLE = 2'd0;
    localparam muldiv_state_t MD_CALC = 2'd1;
    localparam muldiv_state_t MD_FIX  = 2'd2;
    localparam muldiv_state_t MD_DONE = 2'd3;

    // True for the four multi-cycle codes (MULT, MULTU, DIV, DIVU)
    function automatic logic is_muldiv_op(input logic [3:0] code);
        return (code[3:2] == 2'b10);
    endfunction

    // True for the signed variants
    function automatic logic is_signed_op(input logic [3:0] code);
        return (code == ALU_MULT) || (code == ALU_DIV);
    endfunction

endpackage

// File: rtl/muldiv_abs.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign fix-up.
module muldiv_abs
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_data
);

    assign o_data = i_neg ? ((~i_data) + WIDTH'(1)) : i_data;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU take WIDTH iterations plus a fix-up and a done cycle;
// MTHI/MTLO write HI/LO in a single cycle from IDLE.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned CW = $clog2(WIDTH);

    // Architectural and control state
    muldiv_state_t        r_state;
    logic [CW-1:0]        r_cnt;
    logic                 r_is_div;
    logic                 r_neg_res;   // quotient/product must be negated
    logic                 r_neg_rem;   // remainder takes the dividend's sign
    logic [WIDTH-1:0]     r_src1;      // original dividend, needed for divide-by-zero
    logic [WIDTH-1:0]     r_opnd;      // |src2|: multiplicand or divisor
    logic [2*WIDTH-1:0]   r_acc;       // mul: {partial product, multiplier}; div: low half = dividend/quotient
    logic [WIDTH-1:0]     r_rem;       // divide partial remainder
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    // Operand entry
    logic                 w_is_muldiv;
    logic                 w_signed_op;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;

    // Iteration datapath
    logic [WIDTH:0]       w_mul_sum;
    logic [WIDTH:0]       w_div_shift;  // WIDTH+1-bit partial remainder after the shift-in
    logic [WIDTH:0]       w_div_diff;
    logic                 w_div_ge;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [WIDTH-1:0]     w_rem_next;

    // Fix-up datapath
    logic [2*WIDTH-1:0]   w_fix_in;
    logic [2*WIDTH-1:0]   w_fix_res;
    logic [WIDTH-1:0]     w_rem_fix;
    logic                 w_div_zero;

    assign w_is_muldiv = is_muldiv_op(ALUCtrl_i);
    assign w_signed_op = is_signed_op(ALUCtrl_i);

    muldiv_abs #(
        .WIDTH (WIDTH)
    ) u_abs_src1 (
        .i_data (src1_i),
        .i_neg  (w_signed_op & src1_i[WIDTH-1]),
        .o_data (w_abs_a)
    );

    muldiv_abs #(
        .WIDTH (WIDTH)
    ) u_abs_src2 (
        .i_data (src2_i),
        .i_neg  (w_signed_op & src2_i[WIDTH-1]),
        .o_data (w_abs_b)
    );

    // One shift-add or restoring-divide step per cycle
    always_comb begin
        w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
        w_div_shift = {r_rem, r_acc[WIDTH-1]};
        w_div_diff  = w_div_shift - {1'b0, r_opnd};
        // Remainder stays below the divisor, so no borrow means shift >= divisor
        w_div_ge    = ~w_div_diff[WIDTH];
        if (r_is_div) begin
            w_acc_next = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-2:0], w_div_ge};
            w_rem_next = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
        end else begin
            w_acc_next = {w_mul_sum, r_acc[WIDTH-1:1]};
            w_rem_next = r_rem;
        end
    end

    // Sign correction of the raw magnitude result
    always_comb begin
        w_fix_in   = r_is_div ? {{WIDTH{1'b0}}, r_acc[WIDTH-1:0]} : r_acc;
        w_rem_fix  = r_neg_rem ? ((~r_rem) + WIDTH'(1)) : r_rem;
        w_div_zero = (r_opnd == '0);
    end

    muldiv_abs #(
        .WIDTH (2*WIDTH)
    ) u_abs_fix (
        .i_data (w_fix_in),
        .i_neg  (r_neg_res),
        .o_data (w_fix_res)
    );

    // FSM, iteration registers and HI/LO, with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= MD_IDLE;
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_src1    <= '0;
            r_opnd    <= '0;
            r_acc     <= '0;
            r_rem     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (start_i) begin
                        if (w_is_muldiv) begin
                            r_is_div  <= (ALUCtrl_i == ALU_DIV) || (ALUCtrl_i == ALU_DIVU);
                            r_neg_res <= w_signed_op & (src1_i[WIDTH-1] ^ src2_i[WIDTH-1]);
                            r_neg_rem <= w_signed_op & src1_i[WIDTH-1];
                            r_src1    <= src1_i;
                            r_opnd    <= w_abs_b;
                            r_acc     <= {{WIDTH{1'b0}}, w_abs_a};
                            r_rem     <= '0;
                            r_cnt     <= '0;
                            r_state   <= MD_CALC;
                        end else if (ALUCtrl_i == ALU_MTHI) begin
                            r_hi <= src1_i;
                        end else if (ALUCtrl_i == ALU_MTLO) begin
                            r_lo <= src1_i;
                        end
                    end
                end
                MD_CALC: begin
                    r_acc <= w_acc_next;
                    r_rem <= w_rem_next;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_cnt   <= '0;
                        r_state <= MD_FIX;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                MD_FIX: begin
                    if (!r_is_div) begin
                        r_hi <= w_fix_res[2*WIDTH-1:WIDTH];
                        r_lo <= w_fix_res[WIDTH-1:0];
                    end else if (w_div_zero) begin
                        r_hi <= r_src1;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_fix_res[WIDTH-1:0];
                    end
                    r_state <= MD_DONE;
                end
                MD_DONE: begin
                    r_state <= MD_IDLE;
                end
                default: begin
                    r_state <= MD_IDLE;
                end
            endcase
        end
    end

    assign busy_o = (r_state != MD_IDLE);
    assign done_o = (r_state == MD_DONE);
    assign hi_o   = r_hi;
    assign lo_o   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random ops
// checked against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  ctrl;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    // Expected architectural HI/LO
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    localparam logic [3:0] OP_MULT  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIV   = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_MTHI  = 4'b1110;
    localparam logic [3:0] OP_MTLO  = 4'b1111;
    localparam logic [3:0] OP_ADD   = 4'b0010;

    mult_div_unit #(
        .WIDTH (32)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .ALUCtrl_i (ctrl),
        .src1_i    (src1),
        .src2_i    (src2),
        .busy_o    (busy),
        .done_o    (done),
        .hi_o      (hi),
        .lo_o      (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference results from ordinary 64-bit / integer arithmetic
    function automatic void model(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] h,
                                  output logic [31:0] l);
        logic [63:0] up;
        longint      sa;
        longint      sb;
        longint      sp;
        int          ia;
        int          ib;
        h = '0;
        l = '0;
        case (op)
            OP_MULTU: begin
                up = 64'(a) * 64'(b);
                h  = up[63:32];
                l  = up[31:0];
            end
            OP_MULT: begin
                sa = $signed(a);
                sb = $signed(b);
                sp = sa * sb;
                up = sp;
                h  = up[63:32];
                l  = up[31:0];
            end
            OP_DIVU: begin
                if (b == 0) begin
                    l = 32'hFFFF_FFFF;
                    h = a;
                end else begin
                    l = a / b;
                    h = a % b;
                end
            end
            default: begin
                if (b == 0) begin
                    l = 32'hFFFF_FFFF;
                    h = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    l = 32'h8000_0000;
                    h = 32'h0;
                end else begin
                    ia = $signed(a);
                    ib = $signed(b);
                    l  = ia / ib;
                    h  = ia % ib;
                end
            end
        endcase
    endfunction

    // Issue one MULT/DIV op and check timing, hold behaviour and result.
    // inject: throw a MULT and an MTHI at the unit while it is busy.
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit inject);
        logic [31:0] eh;
        logic [31:0] el;
        int k;
        int pulses;
        model(op, a, b, eh, el);
        @(negedge clk);
        start = 1'b1;
        ctrl  = op;
        src1  = a;
        src2  = b;
        @(negedge clk);
        start = 1'b0;
        chk({name, ":busy_rise"}, 32'(busy), 32'd1);
        k = 0;
        while (done !== 1'b1 && k < 60) begin
            if (inject) begin
                if (k == 5) begin
                    start = 1'b1;
                    ctrl  = OP_MULT;
                    src1  = 32'h1234_5678;
                    src2  = 32'h0000_0003;
                end else if (k == 6) begin
                    ctrl = OP_MTHI;
                    src1 = 32'hDEAD_BEEF;
                end else if (k == 7) begin
                    start = 1'b0;
                end
            end
            if (k == 16) begin
                chk({name, ":hold_hi"}, hi, m_hi);
                chk({name, ":hold_lo"}, lo, m_lo);
            end
            @(negedge clk);
            k++;
        end
        chk({name, ":latency"}, 32'(k), 32'd33);
        chk({name, ":hi"}, hi, eh);
        chk({name, ":lo"}, lo, el);
        m_hi = eh;
        m_lo = el;
        pulses = 0;
        @(negedge clk);
        if (done === 1'b1) pulses++;
        chk({name, ":done_width"}, 32'(pulses), 32'd0);
        chk({name, ":busy_fall"}, 32'(busy), 32'd0);
        chk({name, ":hi_after"}, hi, m_hi);
        chk({name, ":lo_after"}, lo, m_lo);
    endtask

    task automatic mt_write(input string name, input logic [3:0] op, input logic [31:0] v);
        @(negedge clk);
        start = 1'b1;
        ctrl  = op;
        src1  = v;
        src2  = $urandom;
        @(negedge clk);
        start = 1'b0;
        if (op == OP_MTHI) m_hi = v;
        if (op == OP_MTLO) m_lo = v;
        chk({name, ":busy"}, 32'(busy), 32'd0);
        chk({name, ":hi"}, hi, m_hi);
        chk({name, ":lo"}, lo, m_lo);
    endtask

    task automatic reset_mid_div();
        int k;
        int pulses;
        @(negedge clk);
        start = 1'b1;
        ctrl  = OP_DIV;
        src1  = 32'h7654_3210;
        src2  = 32'h0000_0013;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (k < 10) begin
            @(negedge clk);
            k++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        m_hi = '0;
        m_lo = '0;
        chk("rst_mid:busy", 32'(busy), 32'd0);
        chk("rst_mid:done", 32'(done), 32'd0);
        chk("rst_mid:hi", hi, 32'h0);
        chk("rst_mid:lo", lo, 32'h0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        chk("rst_mid:no_done", 32'(pulses), 32'd0);
    endtask

    initial begin
        logic [3:0]  ops [4];
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        ops[0] = OP_MULT;
        ops[1] = OP_MULTU;
        ops[2] = OP_DIV;
        ops[3] = OP_DIVU;

        rst   = 1'b1;
        start = 1'b0;
        ctrl  = '0;
        src1  = '0;
        src2  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset:busy", 32'(busy), 32'd0);
        chk("reset:done", 32'(done), 32'd0);
        chk("reset:hi", hi, 32'h0);
        chk("reset:lo", lo, 32'h0);

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0);
        run_op("mult_min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("divu", OP_DIVU, 32'd100, 32'd7, 1'b0);
        run_op("divu_zero", OP_DIVU, 32'h0000_1234, 32'd0, 1'b0);
        run_op("div_zero_neg", OP_DIV, 32'hFFFF_FF00, 32'd0, 1'b0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("busy_ignore", OP_DIVU, 32'hABCD_0123, 32'h0000_0321, 1'b1);
        mt_write("mtlo", OP_MTLO, 32'hCAFE_F00D);
        mt_write("mthi", OP_MTHI, 32'h1357_9BDF);
        mt_write("other_code", OP_ADD, 32'h5555_AAAA);

        reset_mid_div();
        run_op("mult_after_rst", OP_MULT, 32'd6, 32'd7, 1'b0);

        for (int i = 0; i < 16; i++) begin
            op = ops[$urandom_range(0, 3)];
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = $urandom_range(1, 20);
                2: a = $urandom_range(0, 1000);
                3: b = -$urandom_range(1, 20);
                default: ;
            endcase
            run_op("random", op, a, b, 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                mt_write("random_mt", ($urandom_range(0, 1) == 0) ? OP_MTHI : OP_MTLO, $urandom);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
